module_8_64: RTL and testbench
==============================

MODULE_8_64 -- requirements
Module: module_8_64

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of assembled 64-bit words held in the output FIFO; power of two, range 2..16.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 ready_in  input  1  upstream serializer has a word available.
REQ-005 req_data  output  1  one-cycle pulse requesting one word from upstream.
REQ-006 strobe_in  input  1  data_in valid this cycle.
REQ-007 data_in  input  8  incoming byte.
REQ-008 data_end_in  input  1  qualifies the last byte of the current word; valid only with strobe_in.
REQ-009 word_valid  output  1  FIFO head valid.
REQ-010 word_ready  input  1  downstream accepts the head when word_valid is high.
REQ-011 word_data  output  64  assembled word.
REQ-012 word_bytes  output  4  byte count of the head word, 1..8.
REQ-013 err_drop  output  1  sticky flag: a byte was received outside an open request.
REQ-014 chk_out  output  8  XOR checksum of the head word (see Configuration).

Function
REQ-015 FSM states: IDLE, REQ, COLLECT, PUSH.
REQ-016 IDLE->REQ when ready_in=1 and the FIFO has at least one free entry; otherwise IDLE holds.
REQ-017 REQ lasts exactly one cycle; req_data=1 only in REQ; REQ->COLLECT unconditionally.
REQ-018 In COLLECT, each strobe_in byte k (k=0..7) is written to bits [8k+7:8k]; the byte count increments.
REQ-019 COLLECT->PUSH on a strobe with data_end_in=1 or on the 8th byte, whichever comes first.
REQ-020 Unwritten bytes of a partial word are 0; word_bytes equals the bytes received.
REQ-021 PUSH writes {word, count, checksum} into the FIFO in one cycle, clears the assembly register, then goes to IDLE.
REQ-022 Latency: last byte at edge N -> FIFO write at edge N+1 -> word_valid=1 after edge N+1 if the FIFO was empty.
REQ-023 A strobe_in in IDLE, REQ or PUSH is dropped and sets err_drop; the FSM is unaffected.
REQ-024 The FIFO is first-word-fall-through: word_data, word_bytes and chk_out present the head while word_valid=1.
REQ-025 A pop occurs when word_valid & word_ready.
REQ-026 A simultaneous push and pop is legal in any fill state, including full, and leaves the occupancy unchanged.
REQ-027 The FSM never pushes into a full FIFO, because of the REQ-016 free-entry check.
REQ-028 word_ready with an empty FIFO has no effect.
REQ-029 The FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-030 data_end_in without strobe_in is ignored.

Reset
REQ-031 reset_n=0 at an edge forces: state IDLE, req_data=0, assembly register and count cleared, FIFO emptied, word_valid=0, word_data=0, word_bytes=0, chk_out=0, err_drop=0.
REQ-032 Reset asserted mid-COLLECT discards the partial word; no push occurs.
REQ-033 The first req_data can occur no earlier than the second edge after reset_n rises.

Configuration
REQ-034 Macro MODULE_8_64_CHK_EN defined: an 8-bit XOR of all received bytes of each word is computed, stored per FIFO entry and presented on chk_out.
REQ-035 Macro MODULE_8_64_CHK_EN undefined: no checksum storage; chk_out is tied to 0.

Structure
REQ-036 Package module_8_64_pkg holds the state enum, the BYTES_PER_WORD=8 constant and the FIFO entry struct (data, bytes, chk).
REQ-037 Sub-module word_fifo (parameter FIFO_DEPTH, FWFT, entry-struct payload) implements the FIFO; the FSM and assembler stay in module_8_64.

Verification
REQ-038 Reset held 15 cycles, then ready_in=1 -> exactly one req_data pulse on the 2nd edge after release; all outputs 0 during reset.
REQ-039 Bytes 0x11..0x88 with data_end_in on 0x88, word_ready=1 -> word_data=0x8877665544332211, word_bytes=8, chk_out=0x88 with MODULE_8_64_CHK_EN (0 without), word_valid one cycle after PUSH.
REQ-040 Bytes 0xAA,0xBB with data_end_in on 0xBB -> word_data=0x000000000000BBAA, word_bytes=2.
REQ-041 word_ready=0, ready_in=1, full words sent on each request -> exactly 4 words accepted and no 5th req_data; word_ready=1 drains in order 4 words, then the FSM resumes requesting.
REQ-042 strobe_in=1 in IDLE -> err_drop=1 and stays 1, no FIFO write; reset clears it.
REQ-043 reset_n=0 after 3 bytes in COLLECT -> FIFO empty, next word starts at byte 0.

Source files
------------

// File: rtl/module_8_64_pkg.sv
// Shared types for the module_8_64 byte-to-word assembler.
// The checksum field is only populated when MODULE_8_64_CHK_EN is defined.
package module_8_64_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        PUSH
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [3:0]        bytes;
        logic [7:0]        chk;
    } fifo_entry_t;

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO of assembled words; head fields read as zero while empty.
// Checksum storage exists only when MODULE_8_64_CHK_EN is defined.
module word_fifo
    import module_8_64_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        valid_o,
    output fifo_entry_t head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] data_mem  [FIFO_DEPTH];
    logic [3:0]        bytes_mem [FIFO_DEPTH];
`ifdef MODULE_8_64_CHK_EN
    logic [7:0]        chk_mem   [FIFO_DEPTH];
`else
    logic              unused_chk;
    assign unused_chk = ^entry_i.chk;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && valid_o;
    // A pop in the same cycle frees the slot, so push-while-full is accepted then.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is left unreset on purpose; head_o is gated by valid_o so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr_q]  <= entry_i.data;
            bytes_mem[wr_ptr_q] <= entry_i.bytes;
`ifdef MODULE_8_64_CHK_EN
            chk_mem[wr_ptr_q]   <= entry_i.chk;
`endif
        end
    end

    always_comb begin
        head_o = '0;
        if (valid_o) begin
            head_o.data  = data_mem[rd_ptr_q];
            head_o.bytes = bytes_mem[rd_ptr_q];
`ifdef MODULE_8_64_CHK_EN
            head_o.chk   = chk_mem[rd_ptr_q];
`endif
        end
    end

endmodule

// File: rtl/module_8_64.sv
// Requests words from an upstream serializer, packs up to 8 bytes per word, queues them in word_fifo.
// Define MODULE_8_64_CHK_EN to compute and present a per-word XOR checksum on chk_out.
module module_8_64
    import module_8_64_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ready_in,
    output logic        req_data,
    input  logic        strobe_in,
    input  logic [7:0]  data_in,
    input  logic        data_end_in,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [63:0] word_data,
    output logic [3:0]  word_bytes,
    output logic        err_drop,
    output logic [7:0]  chk_out
);

    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              push;
    logic              fifo_full;
    fifo_entry_t       push_entry, head;
`ifdef MODULE_8_64_CHK_EN
    logic [7:0]        chk_q, chk_d;
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        push     = 1'b0;
        req_data = 1'b0;
`ifdef MODULE_8_64_CHK_EN
        chk_d    = chk_q;
`endif
        // Bytes arriving outside an open request are discarded but remembered.
        if (strobe_in && (state_q != COLLECT)) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (ready_in && !fifo_full) state_d = REQ;
            end
            REQ: begin
                req_data = 1'b1;
                state_d  = COLLECT;
            end
            COLLECT: begin
                if (strobe_in) begin
                    asm_d[{cnt_q[2:0], 3'b000} +: 8] = data_in;
                    cnt_d = cnt_q + 4'd1;
`ifdef MODULE_8_64_CHK_EN
                    chk_d = chk_q ^ data_in;
`endif
                    if (data_end_in || (cnt_q == LAST_BYTE)) state_d = PUSH;
                end
            end
            PUSH: begin
                push    = 1'b1;
                asm_d   = '0;
                cnt_d   = '0;
`ifdef MODULE_8_64_CHK_EN
                chk_d   = '0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            asm_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef MODULE_8_64_CHK_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MODULE_8_64_CHK_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        push_entry.data  = asm_q;
        push_entry.bytes = cnt_q;
`ifdef MODULE_8_64_CHK_EN
        push_entry.chk   = chk_q;
`else
        push_entry.chk   = '0;
`endif
    end

    word_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (word_ready),
        .full_o  (fifo_full),
        .valid_o (word_valid),
        .head_o  (head)
    );

    assign word_data  = head.data;
    assign word_bytes = head.bytes;
    assign chk_out    = head.chk;
    assign err_drop   = err_q;

endmodule

// File: tb/tb_module_8_64.sv
// Directed, table-driven bench for module_8_64 with FIFO_DEPTH=4.
// Expected checksums follow MODULE_8_64_CHK_EN (zero when undefined).
module tb_module_8_64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready_in = 1'b0;
    logic        req_data;
    logic        strobe_in = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_end_in = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [63:0] word_data;
    logic [3:0]  word_bytes;
    logic        err_drop;
    logic [7:0]  chk_out;

    int n_vec = 0;
    int n_bad = 0;
    int req_pulses = 0;
    int base;

    typedef struct {
        logic [63:0] bytes_in;
        int          n;
        bit          use_end;
        bit          gap;
        logic [63:0] exp_data;
        logic [3:0]  exp_bytes;
        logic [7:0]  exp_chk;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] full_words [4];

    always #5 clk = ~clk;

    always @(posedge clk) if (req_data === 1'b1) req_pulses <= req_pulses + 1;

    module_8_64 #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ready_in    (ready_in),
        .req_data    (req_data),
        .strobe_in   (strobe_in),
        .data_in     (data_in),
        .data_end_in (data_end_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_bytes  (word_bytes),
        .err_drop    (err_drop),
        .chk_out     (chk_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_chk_of(input logic [7:0] c);
`ifdef MODULE_8_64_CHK_EN
        return c;
`else
        return 8'h00;
`endif
    endfunction

    // Waits (bounded) for a request, then streams n bytes starting one cycle after REQ.
    task automatic send_word(input logic [63:0] b, input int n, input bit use_end,
                             input bit gap, input bit keep_ready);
        int t = 0;
        ready_in = 1'b1;
        while (req_data !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", {63'd0, req_data}, 64'd1);
        if (!keep_ready) ready_in = 1'b0;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            strobe_in   = 1'b1;
            data_in     = b[8*k +: 8];
            data_end_in = use_end && (k == n - 1);
            @(negedge clk);
            if (gap && k == 0) begin
                strobe_in   = 1'b0;
                data_end_in = 1'b1;
                @(negedge clk);
            end
        end
        strobe_in   = 1'b0;
        data_end_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'h8877665544332211, 8, 1'b1, 1'b0, 64'h8877665544332211, 4'd8, 8'h88};
        vecs[1] = '{64'h000000000000BBAA, 2, 1'b1, 1'b0, 64'h000000000000BBAA, 4'd2, 8'h11};
        vecs[2] = '{64'h000000000000005A, 1, 1'b1, 1'b0, 64'h000000000000005A, 4'd1, 8'h5A};
        vecs[3] = '{64'h8040201008040201, 8, 1'b0, 1'b1, 64'h8040201008040201, 4'd8, 8'hFF};
        vecs[4] = '{64'h0000000000BEADDE, 3, 1'b1, 1'b1, 64'h0000000000BEADDE, 4'd3, 8'hCD};
        full_words[0] = 64'hA7A6A5A4A3A2A1A0;
        full_words[1] = 64'hB7B6B5B4B3B2B1B0;
        full_words[2] = 64'hC7C6C5C4C3C2C1C0;
        full_words[3] = 64'hD7D6D5D4D3D2D1D0;

        // Reset held 15 cycles with ready_in high: everything stays zero.
        ready_in = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check("rst_ctl", {49'd0, req_data, word_valid, word_bytes, err_drop, chk_out}, 64'd0);
            check("rst_data", word_data, 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("first_req_high", {63'd0, req_data}, 64'd1);
        ready_in = 1'b0;
        @(negedge clk);
        check("first_req_low", {63'd0, req_data}, 64'd0);
        check("req_pulse_count", 64'(req_pulses), 64'd1);

        // Three bytes into COLLECT, then reset: the partial word must vanish.
        for (int k = 1; k <= 3; k++) begin
            strobe_in = 1'b1;
            data_in   = 8'(k);
            @(negedge clk);
        end
        strobe_in = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        check("midrst_valid", {63'd0, word_valid}, 64'd0);
        check("midrst_bytes", {60'd0, word_bytes}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i].bytes_in, vecs[i].n, vecs[i].use_end, vecs[i].gap, 1'b0);
            check($sformatf("v%0d_latency", i), {63'd0, word_valid}, 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {63'd0, word_valid}, 64'd1);
            check($sformatf("v%0d_data", i), word_data, vecs[i].exp_data);
            check($sformatf("v%0d_bytes", i), {60'd0, word_bytes}, {60'd0, vecs[i].exp_bytes});
            check($sformatf("v%0d_chk", i), {56'd0, chk_out}, {56'd0, exp_chk_of(vecs[i].exp_chk)});
            word_ready = 1'b1;
            @(negedge clk);
            word_ready = 1'b0;
            check($sformatf("v%0d_popped", i), {63'd0, word_valid}, 64'd0);
        end
        check("no_err_in_collect", {63'd0, err_drop}, 64'd0);

        // Fill to capacity with word_ready low: only 4 requests may be issued.
        base = req_pulses;
        for (int w = 0; w < 4; w++) send_word(full_words[w], 8, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("full_req_count", 64'(req_pulses - base), 64'd4);
        check("full_valid", {63'd0, word_valid}, 64'd1);
        word_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            check($sformatf("drain_%0d", w), word_data, full_words[w]);
            @(negedge clk);
        end
        word_ready = 1'b0;
        check("drain_empty", {63'd0, word_valid}, 64'd0);
        check("resume_req", 64'(req_pulses - base), 64'd5);
        ready_in = 1'b0;

        // Stray strobe in IDLE sets the sticky error; reset clears it.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        strobe_in = 1'b1;
        data_in   = 8'h77;
        @(negedge clk);
        strobe_in = 1'b0;
        check("err_set", {63'd0, err_drop}, 64'd1);
        check("err_no_push", {63'd0, word_valid}, 64'd0);
        repeat (3) @(negedge clk);
        check("err_sticky", {63'd0, err_drop}, 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("err_cleared", {63'd0, err_drop}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
